// File: rtl/adsr_envelope.sv
// rtl/adsr_envelope.sv - ADSR amplitude envelope generator
//
// Purpose: gate-driven envelope FSM producing one LEVEL_W-bit amplitude per
// voice. Gate edges move the FSM on any clk; level arithmetic and the sustain
// hold counter only advance on the one-clk sample strobe (tick).
// Optional feature macro: ADSR_RETRIGGER_EN (rise during RELEASE restarts ATTACK
// from the current level instead of being ignored).
//
// Ports:
//   clk          in   rising-edge system clock
//   reset        in   synchronous, active-high
//   tick         in   sample strobe, one clk wide
//   note_gate    in   key held (level)
//   sustain_time in   hold length in SUSTAIN_UNIT ticks
//   env_level    out  registered envelope level
//   env_state    out  0 IDLE, 1 ATTACK, 2 DECAY, 3 SUSTAIN, 4 RELEASE
//   env_active   out  high while not IDLE
//   env_done     out  one-clk pulse on RELEASE -> IDLE

module adsr_envelope #(
  parameter int LEVEL_W       = 8,
  parameter int ATTACK_STEP   = 8,
  parameter int DECAY_STEP    = 2,
  parameter int SUSTAIN_LEVEL = 160,
  parameter int RELEASE_STEP  = 4,
  parameter int SUSTAIN_UNIT  = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               note_gate,
  input  logic [3:0]         sustain_time,
  output logic [LEVEL_W-1:0] env_level,
  output logic [2:0]         env_state,
  output logic               env_active,
  output logic               env_done
);

  localparam int LW1    = LEVEL_W + 1;
  localparam int HOLD_W = 4 + $clog2(SUSTAIN_UNIT);
  localparam int FULL   = (1 << LEVEL_W) - 1;

  localparam logic [LW1-1:0]     FULL_W   = LW1'(FULL);
  localparam logic [LW1-1:0]     ATT_W    = LW1'(ATTACK_STEP);
  localparam logic [LW1-1:0]     DEC_W    = LW1'(DECAY_STEP);
  localparam logic [LW1-1:0]     REL_W    = LW1'(RELEASE_STEP);
  localparam logic [LW1-1:0]     SUST_W   = LW1'(SUSTAIN_LEVEL);
  localparam logic [HOLD_W-1:0]  UNIT_W   = HOLD_W'(SUSTAIN_UNIT);
  localparam logic [HOLD_W-1:0]  HOLD_ONE = HOLD_W'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                gate_q;
  logic                active_q;
  logic                done_q, done_d;

  logic                rise, fall, retrig;
  logic [LW1-1:0]      att_sum, dec_diff, rel_diff;
  logic [HOLD_W-1:0]   hold_load;

  assign rise = note_gate & ~gate_q;
  assign fall = ~note_gate & gate_q;

`ifdef ADSR_RETRIGGER_EN
  assign retrig = rise;
`else
  assign retrig = 1'b0;
`endif

  // One extra bit so saturation/underflow is detected rather than wrapped.
  assign att_sum   = {1'b0, level_q} + ATT_W;
  assign dec_diff  = {1'b0, level_q} - DEC_W;
  assign rel_diff  = {1'b0, level_q} - REL_W;
  assign hold_load = HOLD_W'(sustain_time) * UNIT_W;

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise) state_d = S_ATTACK;
      end
      S_ATTACK: begin
        if (fall) begin
          state_d = S_RELEASE;
        end else if (tick) begin
          if (att_sum >= FULL_W) begin
            level_d = LEVEL_W'(FULL);
            state_d = S_DECAY;
          end else begin
            level_d = att_sum[LEVEL_W-1:0];
          end
        end
      end
      S_DECAY: begin
        if (fall) begin
          state_d = S_RELEASE;
        end else if (tick) begin
          if (dec_diff[LEVEL_W] || dec_diff <= SUST_W) begin
            level_d = LEVEL_W'(SUSTAIN_LEVEL);
            state_d = S_SUSTAIN;
            hold_d  = hold_load;
          end else begin
            level_d = dec_diff[LEVEL_W-1:0];
          end
        end
      end
      S_SUSTAIN: begin
        // An expired hold ends the note even with the key still down.
        if (fall || hold_q == '0) begin
          state_d = S_RELEASE;
        end else if (tick) begin
          hold_d = hold_q - HOLD_ONE;
        end
      end
      S_RELEASE: begin
        if (retrig) begin
          state_d = S_ATTACK;
        end else if (tick) begin
          if (rel_diff[LEVEL_W] || rel_diff == '0) begin
            level_d = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            level_d = rel_diff[LEVEL_W-1:0];
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        level_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      level_q  <= '0;
      hold_q   <= '0;
      gate_q   <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      hold_q   <= hold_d;
      gate_q   <= note_gate;
      active_q <= (state_d != S_IDLE);
      done_q   <= done_d;
    end
  end

  assign env_level  = level_q;
  assign env_state  = state_q;
  assign env_active = active_q;
  assign env_done   = done_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// tb/tb_adsr_envelope.sv - directed bench for adsr_envelope

module tb_adsr_envelope;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       note_gate;
  logic [3:0] sustain_time;
  logic [7:0] env_level;
  logic [2:0] env_state;
  logic       env_active;
  logic       env_done;

  int checks = 0;
  int failures = 0;

  adsr_envelope dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .note_gate    (note_gate),
    .sustain_time (sustain_time),
    .env_level    (env_level),
    .env_state    (env_state),
    .env_active   (env_active),
    .env_done     (env_done)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    note_gate = 1'b0;
    tick      = 1'b1;
    cyc(70);
    tick = 1'b0;
    cyc(2);
  endtask

  task automatic test_reset();
    reset = 1'b1; tick = 1'b0; note_gate = 1'b0; sustain_time = 4'd0;
    cyc(2);
    checks++; if (env_level !== 8'd0) begin failures++; $display("FAIL rst_level got=%0d exp=0", env_level); end
    checks++; if (env_state !== 3'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", env_state); end
    checks++; if (env_active !== 1'b0 || env_done !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b exp=00", env_active, env_done); end
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic test_reset_mid_attack();
    note_gate = 1'b1; tick = 1'b1;
    cyc(9);
    checks++; if (env_level !== 8'd64 || env_state !== 3'd1) begin failures++; $display("FAIL mid_atk got=%0d/%0d exp=64/1", env_level, env_state); end
    reset = 1'b1; note_gate = 1'b0;
    cyc(1);
    checks++; if (env_level !== 8'd0 || env_state !== 3'd0) begin failures++; $display("FAIL mid_rst got=%0d/%0d exp=0/0", env_level, env_state); end
    checks++; if (env_active !== 1'b0 || env_done !== 1'b0) begin failures++; $display("FAIL mid_rst_flags got=%b%b exp=00", env_active, env_done); end
    reset = 1'b0; tick = 1'b0;
    cyc(2);
  endtask

  task automatic test_full_cycle();
    sustain_time = 4'd3; note_gate = 1'b1; tick = 1'b1;
    cyc(1);
    checks++; if (env_state !== 3'd1 || env_level !== 8'd0 || env_active !== 1'b1) begin failures++; $display("FAIL fc_rise got=%0d/%0d/%b exp=1/0/1", env_state, env_level, env_active); end
    cyc(31);
    checks++; if (env_level !== 8'd248 || env_state !== 3'd1) begin failures++; $display("FAIL fc_atk31 got=%0d/%0d exp=248/1", env_level, env_state); end
    cyc(1);
    checks++; if (env_level !== 8'd255 || env_state !== 3'd2) begin failures++; $display("FAIL fc_atk32 got=%0d/%0d exp=255/2", env_level, env_state); end
    cyc(47);
    checks++; if (env_level !== 8'd161 || env_state !== 3'd2) begin failures++; $display("FAIL fc_dec47 got=%0d/%0d exp=161/2", env_level, env_state); end
    cyc(1);
    checks++; if (env_level !== 8'd160 || env_state !== 3'd3) begin failures++; $display("FAIL fc_dec48 got=%0d/%0d exp=160/3", env_level, env_state); end
    cyc(192);
    checks++; if (env_state !== 3'd3 || env_level !== 8'd160) begin failures++; $display("FAIL fc_sus192 got=%0d/%0d exp=3/160", env_state, env_level); end
    cyc(1);
    checks++; if (env_state !== 3'd4 || env_level !== 8'd160) begin failures++; $display("FAIL fc_rel0 got=%0d/%0d exp=4/160", env_state, env_level); end
    cyc(39);
    checks++; if (env_level !== 8'd4 || env_state !== 3'd4 || env_done !== 1'b0) begin failures++; $display("FAIL fc_rel39 got=%0d/%0d/%b exp=4/4/0", env_level, env_state, env_done); end
    cyc(1);
    checks++; if (env_level !== 8'd0 || env_state !== 3'd0 || env_done !== 1'b1 || env_active !== 1'b0) begin failures++; $display("FAIL fc_end got=%0d/%0d/%b/%b exp=0/0/1/0", env_level, env_state, env_done, env_active); end
    cyc(1);
    checks++; if (env_done !== 1'b0 || env_state !== 3'd0) begin failures++; $display("FAIL fc_done_pulse got=%b/%0d exp=0/0", env_done, env_state); end
    go_idle();
  endtask

  task automatic test_sustain_zero();
    sustain_time = 4'd0; note_gate = 1'b1; tick = 1'b1;
    cyc(1 + 32 + 48);
    checks++; if (env_state !== 3'd3 || env_level !== 8'd160) begin failures++; $display("FAIL sz_sus got=%0d/%0d exp=3/160", env_state, env_level); end
    cyc(1);
    checks++; if (env_state !== 3'd4 || env_level !== 8'd160) begin failures++; $display("FAIL sz_rel got=%0d/%0d exp=4/160", env_state, env_level); end
    cyc(1);
    checks++; if (env_level !== 8'd156) begin failures++; $display("FAIL sz_rel1 got=%0d exp=156", env_level); end
    cyc(39);
    checks++; if (env_state !== 3'd0 || env_level !== 8'd0 || env_done !== 1'b1) begin failures++; $display("FAIL sz_end got=%0d/%0d/%b exp=0/0/1", env_state, env_level, env_done); end
    cyc(3);
    checks++; if (env_state !== 3'd0 || env_active !== 1'b0) begin failures++; $display("FAIL sz_held got=%0d/%b exp=0/0", env_state, env_active); end
    go_idle();
  endtask

  task automatic test_fall_in_attack();
    note_gate = 1'b1; tick = 1'b1;
    cyc(16);
    checks++; if (env_level !== 8'd120 || env_state !== 3'd1) begin failures++; $display("FAIL fa_atk got=%0d/%0d exp=120/1", env_level, env_state); end
    note_gate = 1'b0;
    cyc(1);
    checks++; if (env_state !== 3'd4 || env_level !== 8'd120) begin failures++; $display("FAIL fa_edge got=%0d/%0d exp=4/120", env_state, env_level); end
    cyc(1);
    checks++; if (env_level !== 8'd116) begin failures++; $display("FAIL fa_step got=%0d exp=116", env_level); end
    cyc(28);
    checks++; if (env_level !== 8'd4 || env_state !== 3'd4) begin failures++; $display("FAIL fa_rel29 got=%0d/%0d exp=4/4", env_level, env_state); end
    cyc(1);
    checks++; if (env_state !== 3'd0 || env_done !== 1'b1) begin failures++; $display("FAIL fa_end got=%0d/%b exp=0/1", env_state, env_done); end
    go_idle();
  endtask

  task automatic test_retrigger();
    note_gate = 1'b1; tick = 1'b1;
    cyc(11);
    note_gate = 1'b0;
    cyc(1);
    checks++; if (env_state !== 3'd4 || env_level !== 8'd80) begin failures++; $display("FAIL rt_rel got=%0d/%0d exp=4/80", env_state, env_level); end
    tick = 1'b0; note_gate = 1'b1;
    cyc(1);
`ifdef ADSR_RETRIGGER_EN
    checks++; if (env_state !== 3'd1 || env_level !== 8'd80) begin failures++; $display("FAIL rt_edge got=%0d/%0d exp=1/80", env_state, env_level); end
    tick = 1'b1;
    cyc(1);
    checks++; if (env_level !== 8'd88 || env_state !== 3'd1) begin failures++; $display("FAIL rt_step got=%0d/%0d exp=88/1", env_level, env_state); end
`else
    checks++; if (env_state !== 3'd4 || env_level !== 8'd80) begin failures++; $display("FAIL rt_edge got=%0d/%0d exp=4/80", env_state, env_level); end
    tick = 1'b1;
    cyc(1);
    checks++; if (env_level !== 8'd76 || env_state !== 3'd4) begin failures++; $display("FAIL rt_step got=%0d/%0d exp=76/4", env_level, env_state); end
    cyc(19);
    checks++; if (env_state !== 3'd0 || env_level !== 8'd0 || env_done !== 1'b1) begin failures++; $display("FAIL rt_end got=%0d/%0d/%b exp=0/0/1", env_state, env_level, env_done); end
`endif
    go_idle();
  endtask

  task automatic test_no_tick();
    tick = 1'b0; note_gate = 1'b1;
    cyc(1);
    checks++; if (env_state !== 3'd1 || env_level !== 8'd0) begin failures++; $display("FAIL nt_edge got=%0d/%0d exp=1/0", env_state, env_level); end
    cyc(5);
    checks++; if (env_level !== 8'd0) begin failures++; $display("FAIL nt_hold got=%0d exp=0", env_level); end
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    checks++; if (env_level !== 8'd8) begin failures++; $display("FAIL nt_first got=%0d exp=8", env_level); end
    note_gate = 1'b0;
    cyc(1);
    checks++; if (env_state !== 3'd4 || env_level !== 8'd8) begin failures++; $display("FAIL nt_fall got=%0d/%0d exp=4/8", env_state, env_level); end
    tick = 1'b1;
    cyc(2);
    checks++; if (env_state !== 3'd0 || env_level !== 8'd0) begin failures++; $display("FAIL nt_end got=%0d/%0d exp=0/0", env_state, env_level); end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_reset_mid_attack();
    test_full_cycle();
    test_sustain_zero();
    test_fall_in_attack();
    test_retrigger();
    test_no_tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
